// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES-128 controller and its rcon generator.
package aes_pkg;

  localparam int         AES128_ROUNDS = 10;
  localparam logic [7:0] RCON_INIT     = 8'h01;
  localparam logic [7:0] RCON_POLY     = 8'h1b;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RND_INIT  = 2'd0,
    RND_FULL  = 2'd1,
    RND_FINAL = 2'd2
  } rnd_sel_e;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Request/response handshake between the host side and the AES round controller.
interface aes_round_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport master (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid
  );
endinterface

// File: rtl/aes_rcon_gen.sv
// Round-constant register: cleared, seeded with 0x01, or advanced by xtime once per key step.
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic       step,
  input  logic       clear,
  output logic [7:0] rcon
);

  logic [7:0] rcon_q;
  logic [7:0] rcon_d;

  always_comb begin
    rcon_d = rcon_q;
    if (clear) begin
      rcon_d = 8'h00;
    end else if (init) begin
      rcon_d = RCON_INIT;
    end else if (step) begin
      rcon_d = xtime(rcon_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcon_q <= 8'h00;
    end else begin
      rcon_q <= rcon_d;
    end
  end

  assign rcon = rcon_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for the iterative AES-128 datapath: load, 9 full rounds, final round, result handshake.
// Optional AES_ABORT_EN adds an abort input that cancels a block in progress.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int ROUNDS = AES128_ROUNDS,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  aes_round_ctrl_if.slave  hs,
  output logic             ld,
  output logic             st_en,
  output logic             key_step,
  output logic [7:0]       rcon,
  output logic [1:0]       rnd_sel,
  output logic [3:0]       round,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt
`ifdef AES_ABORT_EN
  ,
  input  logic             abort
`endif
);

  localparam logic [3:0] LAST_FULL = 4'(ROUNDS - 1);

  state_e           state_q, state_d;
  logic [3:0]       round_q, round_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             abort_w;
  logic             rcon_init;
  logic             rcon_step;
  logic             rcon_clear;

`ifdef AES_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    blk_cnt_d    = blk_cnt_q;
    rcon_init    = 1'b0;
    rcon_step    = 1'b0;
    rcon_clear   = 1'b0;
    hs.in_ready  = 1'b0;
    hs.out_valid = 1'b0;
    ld           = 1'b0;
    st_en        = 1'b0;
    key_step     = 1'b0;
    busy         = 1'b0;
    rnd_sel      = RND_INIT;

    case (state_q)
      S_IDLE: begin
        hs.in_ready = 1'b1;
        ld          = hs.in_valid;
        if (hs.in_valid) begin
          state_d   = S_ROUND;
          round_d   = 4'd1;
          rcon_init = 1'b1;
        end
      end
      S_ROUND: begin
        busy    = 1'b1;
        rnd_sel = RND_FULL;
        if (abort_w) begin
          state_d    = S_IDLE;
          round_d    = 4'd0;
          rcon_clear = 1'b1;
        end else begin
          st_en     = 1'b1;
          key_step  = 1'b1;
          rcon_step = 1'b1;
          round_d   = round_q + 4'd1;
          if (round_q == LAST_FULL) begin
            state_d = S_FINAL;
          end
        end
      end
      S_FINAL: begin
        busy    = 1'b1;
        rnd_sel = RND_FINAL;
        // rcon is cleared on leaving so it reads 0 in IDLE/DONE without an output mux.
        rcon_clear = 1'b1;
        if (abort_w) begin
          state_d = S_IDLE;
          round_d = 4'd0;
        end else begin
          st_en    = 1'b1;
          key_step = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        hs.out_valid = 1'b1;
        if (hs.out_ready) begin
          state_d   = S_IDLE;
          round_d   = 4'd0;
          blk_cnt_d = blk_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      round_q   <= 4'd0;
      blk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  aes_rcon_gen u_rcon_gen (
    .clk   (clk),
    .reset (reset),
    .init  (rcon_init),
    .step  (rcon_step),
    .clear (rcon_clear),
    .rcon  (rcon)
  );

  assign round   = round_q;
  assign blk_cnt = blk_cnt_q;

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Sequencing controller for the iterative AES-128 encryption core. It accepts one plaintext/key request via a valid/ready handshake and drives the load, round-select and key-step controls of the state register and the on-the-fly key expansion datapath for 10 rounds. It generates the round constant (rcon) for each key-expansion step and presents the result via an output valid/ready handshake. It sits between the host interface and the round and key datapaths, and holds no 128-bit data itself.

## Interface
- ROUNDS, 10: number of AES rounds; fixed for AES-128, exposed only for the bench.
- CNT_W, 16: width of the completed-block counter.

- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  reset, asynchronous, active-high.
- in_valid  in  1  request (plaintext and key presented to the datapath) valid.
- in_ready  out  1  controller can accept a request.
- out_valid  out  1  ciphertext in the state register is valid.
- out_ready  in  1  consumer accepts the ciphertext.
- ld  out  1  datapath loads plaintext XOR key into the state register and key into the key register.
- st_en  out  1  state register enable for a round.
- key_step  out  1  key register advances one expansion step using rcon.
- rcon  out  8  round constant for the current step.
- rnd_sel  out  2  round type: 0 = INIT, 1 = FULL, 2 = FINAL (no MixColumns).
- round  out  4  current round index, 0..10.
- busy  out  1  high in LOAD/ROUND/FINAL.
- blk_cnt  out  CNT_W  number of completed blocks.
- abort  in  1  present only with AES_ABORT_EN.

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid & in_ready: ld = 1, rnd_sel = INIT, round = 0. Go to ROUND with round = 1 and rcon = 0x01.
- **ROUND**
  - st_en = 1, key_step = 1, rnd_sel = FULL.
  - rcon = rcon(round).
  - round increments each cycle.
  - When round == 9, go to FINAL next cycle.
- **FINAL**
  - st_en = 1, key_step = 1, rnd_sel = FINAL, round = 10, rcon = 0x36.
  - Go to DONE.
- **DONE**
  - out_valid = 1, held until out_ready.
  - On out_valid & out_ready: blk_cnt increments and the FSM returns to IDLE.
- rcon update, each step: next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 0x1b : 0x00).
  - Sequence: 01 02 04 08 10 20 40 80 1b 36.
- blk_cnt wraps modulo 2^CNT_W with no saturation.
- in_ready is asserted only in IDLE.
  - A request arriving in DONE waits, even if out_ready is high in the same cycle.
- ld, st_en and key_step are mutually exclusive with respect to ld: ld is never high together with st_en or key_step.
- Outputs are Moore, decoded from registered state, except ld = in_valid & in_ready.
- In IDLE and DONE:
  - st_en, key_step and busy are 0.
  - rcon = 0x00 and rnd_sel = 0.
  - round holds 0 in IDLE and 10 in DONE.

## Timing
- Handshake accepted in cycle T.
- Rounds 1..9 occur in T+1..T+9; FINAL in T+10.
- out_valid rises in T+11. Latency from accept to out_valid is 11 cycles.
- Minimum request-to-request spacing is 12 cycles, with out_ready held high.
- Reset values:
  - FSM = IDLE, round = 0, rcon = 0x00, blk_cnt = 0.
  - out_valid, ld, st_en, key_step and busy = 0.
  - rnd_sel = 0.
  - in_ready = 1.
- Reset asserted mid-operation: the controller returns to IDLE immediately (asynchronously). The partial result is discarded and blk_cnt is cleared.
- out_ready asserted while not in DONE is ignored.

## Configuration
- Macro: AES_ABORT_EN.
- Defined:
  - abort input exists.
  - abort = 1 in ROUND or FINAL: st_en and key_step are forced to 0 in that cycle, and the FSM enters IDLE next cycle.
  - No out_valid is produced and blk_cnt is unchanged.
  - abort has no effect in IDLE or DONE.
- Undefined: the port is absent and the behaviour is as if abort = 0.

## Structure
- Shared package aes_pkg holds:
  - FSM state enum.
  - rnd_sel encodings RND_INIT, RND_FULL, RND_FINAL.
  - RCON_INIT = 8'h01, RCON_POLY = 8'h1b, AES128_ROUNDS = 10.
- One sub-module, aes_rcon_gen: 8-bit rcon register with init, step and clear inputs, implementing the xtime update.

## Test plan
- **Single block:** after reset, pulse in_valid for 1 cycle with out_ready = 1.
  - ld is high at T.
  - rcon reads 01,02,04,08,10,20,40,80,1b,36 over T+1..T+10.
  - rnd_sel = FINAL only at T+10.
  - out_valid is high at T+11 and blk_cnt = 1.
- **Output backpressure:** out_ready = 0 for 5 cycles after DONE.
  - out_valid stays high and in_ready stays 0 throughout.
  - Releasing out_ready gives IDLE next cycle.
- **Back-to-back:** in_valid held high continuously with out_ready = 1.
  - Accepts occur every 12 cycles.
  - blk_cnt = 3 after the third out_valid & out_ready.
- **Reset mid-operation:** assert reset at round 5.
  - All outputs go to their reset values immediately and blk_cnt = 0.
  - The next request completes normally with 11-cycle latency.
- **Counter wrap:** force blk_cnt = 16'hFFFF and complete one block; blk_cnt = 0.
- **Abort (AES_ABORT_EN only):** abort at round 3.
  - key_step = 0 in that cycle and IDLE next cycle.
  - No out_valid and blk_cnt unchanged.
